// File: rtl/fpu.sv
// fpu: single-precision IEEE-754 add/sub (and optional multiply) leaf datapath.
// Latency: 1 cycle, registered output; throughput one operation per clock.
// Backpressure: none -- no handshake, the result is overwritten every cycle.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset, clears out to 0
//   a_in    operand A (IEEE-754 single)
//   b_in    operand B (IEEE-754 single)
//   opcode  2'b00 ADD, 2'b01 SUB, 2'b10 MUL (only with FPU_MUL_EN), 2'b11 reserved
//   out     registered result
//
// Build option: define FPU_MUL_EN to build the multiplier. Without it, MUL
// returns 0 like the reserved opcode.
// Rounding is nearest-even; subnormal inputs and results flush to signed zero.
module fpu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic [1:0]  opcode,
  output logic [31:0] out
);

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [30:0] INF_MAG = {8'hFF, 23'd0};

  // Operand classification.
  logic       a_sgn, b_sgn, b_sgn_eff;
  logic [7:0] a_exp, b_exp;
  logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign a_sgn     = a_in[31];
  assign b_sgn     = b_in[31];
  assign a_exp     = a_in[30:23];
  assign b_exp     = b_in[30:23];
  // SUB reuses the add path with b's sign inverted.
  assign b_sgn_eff = b_sgn ^ opcode[0];
  // exp == 0 covers both true zero and subnormals: both are treated as zero.
  assign a_zero    = (a_exp == 8'h00);
  assign b_zero    = (b_exp == 8'h00);
  assign a_inf     = (a_exp == 8'hFF) && (a_in[22:0] == 23'd0);
  assign b_inf     = (b_exp == 8'hFF) && (b_in[22:0] == 23'd0);
  assign a_nan     = (a_exp == 8'hFF) && (a_in[22:0] != 23'd0);
  assign b_nan     = (b_exp == 8'hFF) && (b_in[22:0] != 23'd0);

  // Leading-zero count of a 27-bit value (the highest set bit wins).
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] c;
    c = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) c = 5'(26 - i);
    end
    return c;
  endfunction

  // Shared round-and-pack. n holds {hidden, 23 frac, guard, round, sticky}
  // with the hidden bit at n[26]; exp_in is the biased exponent for that.
  function automatic logic [31:0] round_pack(input logic              sgn,
                                             input logic signed [11:0] exp_in,
                                             input logic [26:0]        n);
    logic [24:0]        mant_r;
    logic signed [11:0] exp_r;
    logic               rnd;
    rnd    = n[2] & (n[1] | n[0] | n[3]);
    mant_r = {1'b0, n[26:3]} + {24'd0, rnd};
    exp_r  = exp_in;
    // Rounding carried out of the mantissa: renormalize.
    if (mant_r[24]) begin
      mant_r = mant_r >> 1;
      exp_r  = exp_r + 12'sd1;
    end
    if (exp_r <= 12'sd0)        return {sgn, 31'd0};
    else if (exp_r >= 12'sd255) return {sgn, INF_MAG};
    else                        return {sgn, exp_r[7:0], mant_r[22:0]};
  endfunction

  // ---------------- Add / subtract path ----------------
  logic               swap, eff_sub, big_sgn;
  logic [7:0]         big_exp, sml_exp, exp_diff;
  logic [23:0]        big_man, sml_man;
  logic [53:0]        sml_wide;
  logic [26:0]        sml_al;
  logic [27:0]        sum;
  logic [4:0]         lz;
  logic [26:0]        add_norm;
  logic signed [11:0] add_exp;
  logic [31:0]        add_res;

  always_comb begin
    // The larger magnitude sets the result sign; compare exp/frac as one field.
    swap     = (b_in[30:0] > a_in[30:0]);
    big_sgn  = swap ? b_sgn_eff : a_sgn;
    big_exp  = swap ? b_exp : a_exp;
    sml_exp  = swap ? a_exp : b_exp;
    big_man  = swap ? {1'b1, b_in[22:0]} : {1'b1, a_in[22:0]};
    sml_man  = swap ? {1'b1, a_in[22:0]} : {1'b1, b_in[22:0]};
    eff_sub  = a_sgn ^ b_sgn_eff;
    exp_diff = big_exp - sml_exp;

    // Align with guard/round/sticky; everything shifted past bit 0 is ORed
    // into the sticky position. Large shifts leave only the sticky bit.
    sml_wide = {sml_man, 3'b000, 27'd0} >> exp_diff;
    if (exp_diff >= 8'd27) sml_al = 27'd1;
    else                   sml_al = {sml_wide[53:28], sml_wide[27] | (|sml_wide[26:0])};

    if (eff_sub) sum = {1'b0, big_man, 3'b000} - {1'b0, sml_al};
    else         sum = {1'b0, big_man, 3'b000} + {1'b0, sml_al};

    lz = lzc27(sum[26:0]);
    if (sum[27]) begin
      add_norm = {sum[27:2], sum[1] | sum[0]};
      add_exp  = $signed({4'd0, big_exp}) + 12'sd1;
    end else begin
      // Shifts beyond 1 only happen for near-equal exponents, where the
      // low bits are exact, so no sticky information is lost.
      add_norm = sum[26:0] << lz;
      add_exp  = $signed({4'd0, big_exp}) - $signed({7'd0, lz});
    end

    if (a_nan || b_nan)          add_res = QNAN;
    else if (a_inf && b_inf)     add_res = (a_sgn != b_sgn_eff) ? QNAN : {a_sgn, INF_MAG};
    else if (a_inf)              add_res = {a_sgn, INF_MAG};
    else if (b_inf)              add_res = {b_sgn_eff, INF_MAG};
    else if (a_zero && b_zero)   add_res = {a_sgn & b_sgn_eff, 31'd0};
    else if (a_zero)             add_res = {b_sgn_eff, b_in[30:0]};
    else if (b_zero)             add_res = a_in;
    else if (sum == 28'd0)       add_res = 32'h0000_0000; // exact cancellation is +0
    else                         add_res = round_pack(big_sgn, add_exp, add_norm);
  end

`ifdef FPU_MUL_EN
  // ---------------- Multiply path ----------------
  logic               mul_sgn;
  logic [47:0]        prod;
  logic [26:0]        mul_norm;
  logic signed [11:0] mul_exp;
  logic [31:0]        mul_res;

  always_comb begin
    mul_sgn = a_sgn ^ b_sgn;
    prod    = {1'b1, a_in[22:0]} * {1'b1, b_in[22:0]};
    // Product of two [1,2) significands lies in [1,4): normalize by 0 or 1.
    if (prod[47]) begin
      mul_norm = {prod[47:22], |prod[21:0]};
      mul_exp  = $signed({4'd0, a_exp}) + $signed({4'd0, b_exp}) - 12'sd126;
    end else begin
      mul_norm = {prod[46:21], |prod[20:0]};
      mul_exp  = $signed({4'd0, a_exp}) + $signed({4'd0, b_exp}) - 12'sd127;
    end

    if (a_nan || b_nan)                            mul_res = QNAN;
    else if ((a_inf && b_zero) || (b_inf && a_zero)) mul_res = QNAN;
    else if (a_inf || b_inf)                       mul_res = {mul_sgn, INF_MAG};
    else if (a_zero || b_zero)                     mul_res = {mul_sgn, 31'd0};
    else                                           mul_res = round_pack(mul_sgn, mul_exp, mul_norm);
  end
`endif

  // ---------------- Result select and register ----------------
  logic [31:0] result;

  always_comb begin
    result = 32'h0000_0000;
    case (opcode)
      2'b00, 2'b01: result = add_res;
`ifdef FPU_MUL_EN
      2'b10:        result = mul_res;
`else
      2'b10:        result = 32'h0000_0000;
`endif
      default:      result = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) out <= 32'h0000_0000;
    else        out <= result;
  end

endmodule

// File: tb/tb_fpu.sv
// tb_fpu: directed-vector bench for fpu with hand-computed expected results.
// Inputs change 1 time unit after a rising edge; out is sampled at that point.
module tb_fpu;

  logic        clk;
  logic        rst_n;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [1:0]  opcode;
  logic [31:0] out;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  fpu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_in   (a_in),
    .b_in   (b_in),
    .opcode (opcode),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Present one operation, clock it in, then check the registered result.
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] op, input logic [31:0] exp);
    a_in   = a;
    b_in   = b;
    opcode = op;
    @(posedge clk);
    #1;
    chk(tag, out, exp);
  endtask

  initial begin
    rst_n  = 1'b0;
    a_in   = 32'h3F80_0000;
    b_in   = 32'h3F80_0000;
    opcode = OP_ADD;

    // Reset held for two edges with 1+1 presented.
    @(posedge clk);
    #1;
    chk("reset_edge1", out, 32'h0000_0000);
    @(posedge clk);
    #1;
    chk("reset_edge2", out, 32'h0000_0000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_release", out, 32'h4000_0000);

    // Back-to-back ADD then SUB, no bubbles.
    run("stream_add", 32'h3F80_0000, 32'h4000_0000, OP_ADD, 32'h4040_0000);
    run("stream_sub", 32'h3F80_0000, 32'h4000_0000, OP_SUB, 32'hBF80_0000);

    // Rounding and alignment.
    run("tie_even",    32'h3F80_0000, 32'h3380_0000, OP_ADD, 32'h3F80_0000);
    run("above_tie",   32'h3F80_0000, 32'h3380_0001, OP_ADD, 32'h3F80_0001);
    run("carry_renorm",32'h4B7F_FFFF, 32'h3F80_0000, OP_ADD, 32'h4B80_0000);
    run("far_shift",   32'h4B80_0000, 32'h3F80_0000, OP_SUB, 32'h4B7F_FFFF);
    run("mixed_sign",  32'h4040_0000, 32'hBF80_0000, OP_ADD, 32'h4000_0000);

    // Cancellation, overflow, flush-to-zero, signed zeros.
    run("cancel",      32'h4049_0FDB, 32'h4049_0FDB, OP_SUB, 32'h0000_0000);
    run("overflow",    32'h7F7F_FFFF, 32'h7F7F_FFFF, OP_ADD, 32'h7F80_0000);
    run("subnorm_ftz", 32'h0040_0000, 32'h0000_0000, OP_ADD, 32'h0000_0000);
    run("negz_negz",   32'h8000_0000, 32'h8000_0000, OP_ADD, 32'h8000_0000);
    run("posz_negz",   32'h0000_0000, 32'h8000_0000, OP_ADD, 32'h0000_0000);
    run("zero_plus_x", 32'h0000_0000, 32'h3F80_0000, OP_SUB, 32'hBF80_0000);

    // Special operands.
    run("inf_minus_inf", 32'h7F80_0000, 32'hFF80_0000, OP_ADD, 32'h7FC0_0000);
    run("inf_sub_fin",   32'h7F80_0000, 32'h3F80_0000, OP_SUB, 32'h7F80_0000);
    run("snan_add",      32'h7FA0_0000, 32'h3F80_0000, OP_ADD, 32'h7FC0_0000);
    run("fin_sub_inf",   32'h3F80_0000, 32'h7F80_0000, OP_SUB, 32'hFF80_0000);

    // Multiply and reserved opcode.
`ifdef FPU_MUL_EN
    run("mul_2x3",     32'h4000_0000, 32'h4040_0000, OP_MUL, 32'h40C0_0000);
    run("mul_inf_0",   32'h7F80_0000, 32'h0000_0000, OP_MUL, 32'h7FC0_0000);
    run("mul_neg",     32'hC000_0000, 32'h3FC0_0000, OP_MUL, 32'hC040_0000);
`else
    run("mul_absent",  32'h4000_0000, 32'h4040_0000, OP_MUL, 32'h0000_0000);
    run("mul_absent2", 32'h7F80_0000, 32'h0000_0000, OP_MUL, 32'h0000_0000);
`endif
    run("reserved_op", 32'h4000_0000, 32'h4040_0000, OP_RSV, 32'h0000_0000);

    // Reset mid-stream discards the pending result.
    a_in   = 32'h3F80_0000;
    b_in   = 32'h4000_0000;
    opcode = OP_ADD;
    rst_n  = 1'b0;
    @(posedge clk);
    #1;
    chk("midrun_reset", out, 32'h0000_0000);
    rst_n = 1'b1;
    run("after_reset", 32'h3F80_0000, 32'h4000_0000, OP_ADD, 32'h4040_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
